// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - scan modes, hex glyph table and segment helpers for sevenseg_scan_counter
package sevenseg_pkg;

   typedef enum logic [1:0] {
      MODE_FAST = 2'd0,
      MODE_MED  = 2'd1,
      MODE_SLOW = 2'd2
   } scan_mode_e;

   // Segment order a..g on bits 6..0; entry 0 is the last element of the concatenation.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

   // The unused encoding behaves as MODE_FAST, so it advances to MODE_MED.
   function automatic scan_mode_e next_mode(input scan_mode_e mode);
      case (mode)
         MODE_MED:  return MODE_SLOW;
         MODE_SLOW: return MODE_FAST;
         default:   return MODE_MED;
      endcase
   endfunction

endpackage

// File: rtl/sevenseg_scan_counter_if.sv
// rtl/sevenseg_scan_counter_if.sv - pushbutton inputs and multiplexed display outputs
interface sevenseg_scan_counter_if #(
   parameter int NUM_DIGITS = 4
);
   logic                  btnleft;
   logic                  btnright;
   logic [NUM_DIGITS-1:0] grounds;
   logic [6:0]            display;
   logic                  dp;

   modport master (
      output btnleft,
      output btnright,
      input  grounds,
      input  display,
      input  dp
   );

   modport slave (
      input  btnleft,
      input  btnright,
      output grounds,
      output display,
      output dp
   );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and release pulse for one button
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic release_pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] stable_cnt;

   // The count restarts whenever the synchronised input agrees with the accepted level,
   // so only an unbroken run of differing samples can flip it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         level         <= 1'b0;
         stable_cnt    <= '0;
         release_pulse <= 1'b0;
      end else begin
         sync1         <= btn;
         sync2         <= sync1;
         release_pulse <= 1'b0;
         if (sync2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST_COUNT) begin
            stable_cnt    <= '0;
            level         <= sync2;
            release_pulse <= level;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/sevenseg_scan_counter.sv
// rtl/sevenseg_scan_counter.sv - debounced hex counter on a multiplexed 7-segment display
// Define LEADING_ZERO_BLANK_EN to blank digits above the highest nonzero digit.
module sevenseg_scan_counter
   import sevenseg_pkg::*;
#(
   parameter int                        NUM_DIGITS      = 4,
   parameter int                        DIV_FAST        = 15,
   parameter int                        DIV_MED         = 19,
   parameter int                        DIV_SLOW        = 25,
   parameter int                        DEBOUNCE_CYCLES = 65536,
   parameter logic [4*NUM_DIGITS-1:0]   INIT_VALUE      = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sevenseg_scan_counter_if.slave bus
);
   localparam int CW = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW_MF = (DIV_MED > DIV_FAST) ? DIV_MED : DIV_FAST;
   localparam int PW = (DIV_SLOW > PW_MF) ? DIV_SLOW : PW_MF;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] MASK_FAST = {PW{1'b1}} >> (PW - DIV_FAST);
   localparam logic [PW-1:0] MASK_MED  = {PW{1'b1}} >> (PW - DIV_MED);
   localparam logic [PW-1:0] MASK_SLOW = {PW{1'b1}} >> (PW - DIV_SLOW);

   logic                  inc_pulse;
   logic                  mode_pulse;
   logic [CW-1:0]         count_q;
   logic                  ovf_q;
   scan_mode_e            mode_q;
   logic [PW-1:0]         presc_q;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_next;
   logic [NUM_DIGITS-1:0] grounds_q;
   logic [PW-1:0]         div_mask;
   logic                  scan_tick;
   logic [IW-1:0]         idx_rev;
   logic [CW-1:0]         upper_bits;
   logic [6:0]            glyph;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn           (bus.btnleft),
      .release_pulse (inc_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn           (bus.btnright),
      .release_pulse (mode_pulse)
   );

   always_comb begin
      case (mode_q)
         MODE_MED:  div_mask = MASK_MED;
         MODE_SLOW: div_mask = MASK_SLOW;
         default:   div_mask = MASK_FAST;
      endcase
   end

   // The tick compares the live mode against a prescaler that is never reset on
   // mode changes, so a new period starts cleanly at the next all-ones match.
   assign scan_tick = ((presc_q & div_mask) == div_mask);

   always_comb begin
      idx_next = idx_q;
      if (scan_tick) begin
         idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q   <= INIT_VALUE;
         ovf_q     <= 1'b0;
         mode_q    <= MODE_FAST;
         presc_q   <= '0;
         idx_q     <= '0;
         grounds_q <= ~NUM_DIGITS'(1);
      end else begin
         presc_q   <= presc_q + 1'b1;
         idx_q     <= idx_next;
         grounds_q <= ~(NUM_DIGITS'(1) << idx_next);
         if (inc_pulse) begin
            count_q <= count_q + 1'b1;
            if (&count_q) begin
               ovf_q <= 1'b1;
            end
         end
         if (mode_pulse) begin
            mode_q <= next_mode(mode_q);
         end
      end
   end

   // Digit 0 is the most significant nibble, so shift by the reversed index.
   assign idx_rev    = LAST_IDX - idx_q;
   assign upper_bits = count_q >> {idx_rev, 2'b00};
   assign glyph      = hex_to_seg(upper_bits[3:0]);

`ifdef LEADING_ZERO_BLANK_EN
   assign bus.display = ((idx_q != LAST_IDX) && (upper_bits == '0)) ? 7'h00 : glyph;
`else
   assign bus.display = glyph;
`endif

   assign bus.grounds = grounds_q;
   assign bus.dp      = (idx_q == LAST_IDX) && ovf_q;

endmodule

// File: tb/tb_sevenseg_scan_counter.sv
// tb/tb_sevenseg_scan_counter.sv - randomized and directed checks of sevenseg_scan_counter against a reference model
module tb_sevenseg_scan_counter;
   localparam int N  = 4;
   localparam int DF = 2;
   localparam int DM = 3;
   localparam int DS = 4;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_l = 1'b0;
   logic btn_r = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   sevenseg_scan_counter_if #(.NUM_DIGITS(N)) bus0 ();
   sevenseg_scan_counter_if #(.NUM_DIGITS(N)) bus1 ();
   sevenseg_scan_counter_if #(.NUM_DIGITS(N)) bus2 ();
   assign bus0.btnleft = btn_l;
   assign bus0.btnright = btn_r;
   assign bus1.btnleft = btn_l;
   assign bus1.btnright = btn_r;
   assign bus2.btnleft = btn_l;
   assign bus2.btnright = btn_r;

   sevenseg_scan_counter #(.NUM_DIGITS(N), .DIV_FAST(DF), .DIV_MED(DM), .DIV_SLOW(DS),
      .DEBOUNCE_CYCLES(DB), .INIT_VALUE(16'h00FF)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   sevenseg_scan_counter #(.NUM_DIGITS(N), .DIV_FAST(DF), .DIV_MED(DM), .DIV_SLOW(DS),
      .DEBOUNCE_CYCLES(DB), .INIT_VALUE(16'hFFFF)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   sevenseg_scan_counter #(.NUM_DIGITS(N), .DIV_FAST(DF), .DIV_MED(DM), .DIV_SLOW(DS),
      .DEBOUNCE_CYCLES(DB), .INIT_VALUE(16'h0005)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Reference model: counters as integers, buttons as a window of raw samples.
   logic [6:0]  glyph_tb [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   int unsigned init_v [3] = '{32'h00FF, 32'hFFFF, 32'h0005};
   int unsigned cnt_m [3];
   bit          ovf_m [3];
   int          mode_m;
   int          idx_m;
   int unsigned p_m;
   bit [5:0]    hl;
   bit [5:0]    hr;
   bit          db_l, db_r, pend_l, pend_r;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LEAD_ZERO_GLYPH = 7'h00;
`else
   localparam logic [6:0] LEAD_ZERO_GLYPH = 7'h7E;
`endif

   function automatic int unsigned mask_of(input int m);
      case (m)
         1:       return (32'd1 << DM) - 1;
         2:       return (32'd1 << DS) - 1;
         default: return (32'd1 << DF) - 1;
      endcase
   endfunction

   // A level is accepted once the debouncer has seen DB synchronised samples (raw from
   // two clocks earlier) that all disagree with it.
   function automatic bit flips(input bit [5:0] h, input bit db);
      return db ? (h[5:2] == 4'h0) : (h[5:2] == 4'hF);
   endfunction

   task automatic reset_model();
      for (int u = 0; u < 3; u++) begin
         cnt_m[u] = init_v[u];
         ovf_m[u] = 1'b0;
      end
      mode_m = 0;
      idx_m  = 0;
      p_m    = 0;
      hl = '0; hr = '0;
      db_l = 0; db_r = 0; pend_l = 0; pend_r = 0;
   endtask

   task automatic model_edge();
      bit tick, fl, fr;
      if (!rst_n) begin
         reset_model();
         return;
      end
      tick = ((p_m & mask_of(mode_m)) == mask_of(mode_m));
      for (int u = 0; u < 3; u++) begin
         if (pend_l) begin
            if (cnt_m[u] == 32'hFFFF) ovf_m[u] = 1'b1;
            cnt_m[u] = (cnt_m[u] + 1) % 65536;
         end
      end
      if (pend_r) mode_m = (mode_m + 1) % 3;
      if (tick) idx_m = (idx_m + 1) % N;
      p_m++;
      hl = {hl[4:0], btn_l};
      hr = {hr[4:0], btn_r};
      fl = flips(hl, db_l);
      fr = flips(hr, db_r);
      pend_l = fl && db_l;
      pend_r = fr && db_r;
      if (fl) db_l = ~db_l;
      if (fr) db_r = ~db_r;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_unit(input int u, input logic [3:0] g, input logic [6:0] d, input logic p);
      logic [3:0]  g_exp;
      int unsigned upper;
      logic [6:0]  d_exp;
      g_exp = ~(4'b0001 << idx_m);
      upper = cnt_m[u] >> (4 * (N - 1 - idx_m));
      d_exp = glyph_tb[upper & 15];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_m != N - 1 && upper == 0) d_exp = 7'h00;
`endif
      check($sformatf("grounds%0d", u), 32'(g), 32'(g_exp));
      check($sformatf("display%0d", u), 32'(d), 32'(d_exp));
      check($sformatf("dp%0d", u), 32'(p), 32'((idx_m == N - 1) && ovf_m[u]));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_unit(0, bus0.grounds, bus0.display, bus0.dp);
      check_unit(1, bus1.grounds, bus1.display, bus1.dp);
      check_unit(2, bus2.grounds, bus2.display, bus2.dp);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic press(input bit l, input bit r, input int hold);
      btn_l = l;
      btn_r = r;
      run(hold);
      btn_l = 1'b0;
      btn_r = 1'b0;
   endtask

   task automatic measure_period(output int len);
      logic [3:0] g0;
      int n;
      g0 = bus0.grounds;
      n = 0;
      while (bus0.grounds == g0 && n < 64) begin cycle(); n++; end
      g0 = bus0.grounds;
      len = 0;
      do begin cycle(); len++; end while (bus0.grounds == g0 && len < 64);
   endtask

   initial begin
      int lat, per, dp_hits, exp_cnt, exp_mode, hold;
      logic [3:0] g_prev;
      int exp_mode_seq [3] = '{1, 2, 0};
      int exp_per_seq [3] = '{8, 16, 4};

      reset_model();
      run(3);
      check("rst_grounds", 32'(bus0.grounds), 32'h0000_000E);
      check("rst_dp", 32'(bus1.dp), 32'h0);
      check("rst_count0", 32'(dut0.count_q), 32'h00FF);
      check("rst_count1", 32'(dut1.count_q), 32'hFFFF);
      check("rst_mode", 32'(dut0.mode_q), 32'h0);
      rst_n = 1'b1;

      // Mode 0 scan: rotation order, glyph of 00FF digit 2, and leading digits of 0005.
      g_prev = bus0.grounds;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (bus0.grounds != g_prev) begin
            check("scan_rotate", 32'(bus0.grounds), 32'({g_prev[2:0], g_prev[3]}));
            g_prev = bus0.grounds;
         end
         if (bus0.grounds == 4'b1011) check("digit2_of_00ff", 32'(bus0.display), 32'h47);
         if (bus2.grounds == 4'b0111) check("lsd_of_0005", 32'(bus2.display), 32'h5B);
         else check("lead_zero_0005", 32'(bus2.display), 32'(LEAD_ZERO_GLYPH));
      end
      measure_period(per);
      check("period_mode0", 32'(per), 32'd4);

      // One long press: increment lands on the 7th clock edge after release.
      btn_l = 1'b1;
      run(10);
      btn_l = 1'b0;
      lat = 0;
      do begin cycle(); lat++; end while (dut0.count_q == 16'h00FF && lat < 20);
      check("inc_latency", 32'(lat), 32'd7);
      check("inc_value", 32'(dut0.count_q), 32'h0100);
      run(10);
      check("inc_once", 32'(dut0.count_q), 32'h0100);
      check("wrap_count", 32'(dut1.count_q), 32'h0000);
      check("wrap_ovf", 32'(dut1.ovf_q), 32'h1);
      check("no_ovf0", 32'(dut0.ovf_q), 32'h0);
      dp_hits = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (bus1.dp) dp_hits++;
      end
      check("dp_lsd_only", 32'(dp_hits), 32'd4);

      // Bounces shorter than the debounce window never register.
      for (int i = 0; i < 20; i += hold) begin
         btn_l = ~btn_l;
         hold = $urandom_range(1, 2);
         run(hold);
      end
      btn_l = 1'b0;
      run(12);
      check("bounce_ignored", 32'(dut0.count_q), 32'h0100);

      // Mode sequence with tick periods.
      for (int k = 0; k < 3; k++) begin
         press(1'b0, 1'b1, 8);
         run(8);
         check($sformatf("mode_step%0d", k), 32'(dut0.mode_q), 32'(exp_mode_seq[k]));
         measure_period(per);
         measure_period(per);
         check($sformatf("period_step%0d", k), 32'(per), 32'(exp_per_seq[k]));
      end

      // Simultaneous release of both buttons.
      exp_cnt  = (cnt_m[0] + 1) % 65536;
      exp_mode = (mode_m + 1) % 3;
      btn_l = 1'b1; btn_r = 1'b1;
      run(8);
      btn_l = 1'b0; btn_r = 1'b0;
      lat = 0;
      do begin cycle(); lat++; end while (dut0.count_q != 16'(exp_cnt) && lat < 20);
      check("both_count", 32'(dut0.count_q), 32'(exp_cnt));
      check("both_mode_same_edge", 32'(dut0.mode_q), 32'(exp_mode));

      // Reset in the middle of a pending release abandons it.
      btn_l = 1'b1;
      run(10);
      btn_l = 1'b0;
      run(3);
      rst_n = 1'b0;
      run(2);
      check("midrst_grounds", 32'(bus0.grounds), 32'h0000_000E);
      rst_n = 1'b1;
      run(20);
      check("midrst_count0", 32'(dut0.count_q), 32'h00FF);
      check("midrst_ovf1", 32'(dut1.ovf_q), 32'h0);
      check("midrst_mode", 32'(dut0.mode_q), 32'h0);

      // Random button activity with occasional resets, checked every clock.
      for (int s = 0; s < 160; s++) begin
         btn_l = 1'($urandom_range(0, 1));
         btn_r = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
         run($urandom_range(1, 10));
         rst_n = 1'b1;
      end
      btn_l = 1'b0;
      btn_r = 1'b0;
      run(12);
      check("rand_count0", 32'(dut0.count_q), cnt_m[0]);
      check("rand_mode", 32'(dut0.mode_q), 32'(mode_m));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
